// File: rtl/pulse_timer_pkg.sv
// Shared types and constants for the multi-channel start/done pulse timer.
package pulse_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} tmr_state_t;

  localparam int EVCNT_W = 8;

endpackage

// File: rtl/pulse_timer_ch.sv
// One pulse-timer channel: measures start high time, ends on release or limit.
// Optional per-channel timeout event counter enabled by PULSE_TIMER_EVCNT_EN.
module pulse_timer_ch
  import pulse_timer_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] limit,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [N-1:0] len
`ifdef PULSE_TIMER_EVCNT_EN
  ,
  output logic [EVCNT_W-1:0] tmo_cnt
`endif
);

  tmr_state_t   state;
  logic [N-1:0] cnt;
  logic [N-1:0] lim_q;
  logic [N-1:0] lim_eff;

  // A zero limit means "run to the top of the counter" so it never wraps.
  always_comb begin
    lim_eff = lim_q;
    if (lim_q == '0) lim_eff = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lim_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      len     <= '0;
`ifdef PULSE_TIMER_EVCNT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= RUN;
            lim_q <= limit;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // Release wins over a simultaneous limit hit.
          if (!start) begin
            state   <= DONE;
            len     <= cnt;
            timeout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (cnt == lim_eff) begin
            state   <= DONE;
            len     <= cnt;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef PULSE_TIMER_EVCNT_EN
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= start ? HOLD : IDLE;
        end
        HOLD: begin
          // A start still held from the last run must drop before re-arming.
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_timer_mc.sv
// Multi-channel start/done pulse timer: NCH independent pulse_timer_ch copies.
// Build with PULSE_TIMER_EVCNT_EN to expose per-channel timeout event counters.
module pulse_timer_mc
  import pulse_timer_pkg::*;
#(
  parameter int N   = 3,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   start,
  input  logic [NCH*N-1:0] limit,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   timeout,
  output logic [NCH*N-1:0] len
`ifdef PULSE_TIMER_EVCNT_EN
  ,
  output logic [NCH*EVCNT_W-1:0] tmo_cnt
`endif
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    pulse_timer_ch #(.N(N)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start[gi]),
      .limit   (limit[gi*N +: N]),
      .busy    (busy[gi]),
      .done    (done[gi]),
      .timeout (timeout[gi]),
      .len     (len[gi*N +: N])
`ifdef PULSE_TIMER_EVCNT_EN
      ,
      .tmo_cnt (tmo_cnt[gi*EVCNT_W +: EVCNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_pulse_timer_mc.sv
// Scoreboard bench for pulse_timer_mc: elapsed-time reference model feeds
// per-channel expectation queues, a negedge monitor checks every DUT cycle.
module tb_pulse_timer_mc;
  import pulse_timer_pkg::*;

  localparam int N    = 3;
  localparam int NCH  = 4;
  localparam int MAXV = (1 << N) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH-1:0]   start = '0;
  logic [NCH*N-1:0] limit = '0;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;
  logic [NCH-1:0]   timeout;
  logic [NCH*N-1:0] len;
`ifdef PULSE_TIMER_EVCNT_EN
  logic [NCH*EVCNT_W-1:0] tmo_cnt;
`endif

  pulse_timer_mc #(.N(N), .NCH(NCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .limit   (limit),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .len     (len)
`ifdef PULSE_TIMER_EVCNT_EN
    ,
    .tmo_cnt (tmo_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int len;
    int tmo;
    int evc;
  } exp_t;

  exp_t expq[NCH][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   running[NCH];
  bit   pend_done[NCH];
  bit   blocked[NCH];
  int   t0[NCH];
  int   deadline[NCH];
  int   lim_m[NCH];
  int   evc_m[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a run starting at edge t0 ends at the first edge where
  // start is low (len = elapsed-1) or at edge t0+lim+1 (len = lim, timeout).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        expq[i].delete();
        running[i]   = 1'b0;
        pend_done[i] = 1'b0;
        blocked[i]   = 1'b0;
        evc_m[i]     = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        exp_t e;
        if (running[i]) begin
          if (!start[i] || cyc == deadline[i]) begin
            e.edge_no = cyc;
            e.tmo     = start[i] ? 1 : 0;
            e.len     = start[i] ? lim_m[i] : (cyc - t0[i] - 1);
            if (e.tmo == 1 && evc_m[i] < 255) evc_m[i]++;
            e.evc = evc_m[i];
            expq[i].push_back(e);
            running[i]   = 1'b0;
            pend_done[i] = 1'b1;
          end
        end else if (pend_done[i]) begin
          pend_done[i] = 1'b0;
          blocked[i]   = start[i];
        end else if (blocked[i]) begin
          if (!start[i]) blocked[i] = 1'b0;
        end else if (start[i]) begin
          running[i]  = 1'b1;
          t0[i]       = cyc;
          lim_m[i]    = (limit[i*N +: N] == 0) ? MAXV : int'(limit[i*N +: N]);
          deadline[i] = cyc + lim_m[i] + 1;
        end
      end
    end
  end

  // Monitor: every done must match the head of its channel queue on the exact cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        exp_t e;
        if (expq[i].size() > 0 && expq[i][0].edge_no == cyc) begin
          e = expq[i].pop_front();
          check($sformatf("done ch%0d", i), 32'(done[i]), 1);
          check($sformatf("len ch%0d", i), 32'(len[i*N +: N]), e.len);
          check($sformatf("timeout ch%0d", i), 32'(timeout[i]), e.tmo);
`ifdef PULSE_TIMER_EVCNT_EN
          check($sformatf("tmo_cnt ch%0d", i), 32'(tmo_cnt[i*EVCNT_W +: EVCNT_W]), e.evc);
`endif
          $display("done ch%0d cycle %0d len=%0d timeout=%0d", i, cyc, len[i*N +: N], timeout[i]);
        end else begin
          check($sformatf("no_done ch%0d", i), 32'(done[i]), 0);
        end
        check($sformatf("busy ch%0d", i), 32'(busy[i]), 32'(running[i]));
      end
    end
  end

  initial begin
    #3;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset timeout", 32'(timeout), 0);
    check("reset len", 32'(len), 0);
    #9 reset_n = 1'b1;
    tick();

    // Release: ch0 limit 6, start high for 4 edges.
    limit[0 +: N] = 3'd6;
    start[0] = 1'b1;
    repeat (4) tick();
    start[0] = 1'b0;
    repeat (3) tick();
    check("dir release len", 32'(len[0 +: N]), 3);
    check("dir release tmo", 32'(timeout[0]), 0);

    // Timeout: ch1 limit 5, start held; must sit in HOLD without a second done.
    limit[N +: N] = 3'd5;
    start[1] = 1'b1;
    repeat (12) tick();
    check("dir timeout len", 32'(len[N +: N]), 5);
    check("dir timeout tmo", 32'(timeout[1]), 1);
    start[1] = 1'b0;
    repeat (3) tick();

    // Limit 0 means all-ones.
    limit[2*N +: N] = 3'd0;
    start[2] = 1'b1;
    repeat (12) tick();
    check("dir lim0 len", 32'(len[2*N +: N]), 7);
    check("dir lim0 tmo", 32'(timeout[2]), 1);
    start[2] = 1'b0;
    repeat (3) tick();

    // Concurrency with limits scrambled during RUN.
    limit = {3'd0, 3'd3, 3'd2, 3'd1};
    start = '1;
    tick();
    repeat (11) begin
      limit = NCH*N'($urandom);
      tick();
    end
    check("conc len", 32'(len), 32'({3'd7, 3'd3, 3'd2, 3'd1}));
    check("conc tmo", 32'(timeout), 32'(4'b1111));
    start = '0;
    repeat (3) tick();

    // Asynchronous reset mid-RUN.
    limit[0 +: N] = 3'd6;
    start[0] = 1'b1;
    tick();
    tick();
    #1 reset_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst done", 32'(done), 0);
    check("midrst timeout", 32'(timeout), 0);
    check("midrst len", 32'(len), 0);
    start = '0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) tick();

`ifdef PULSE_TIMER_EVCNT_EN
    limit[3*N +: N] = 3'd1;
    repeat (300) begin
      start[3] = 1'b1;
      repeat (3) tick();
      start[3] = 1'b0;
      repeat (2) tick();
    end
    start[3] = 1'b1;
    repeat (2) tick();
    start[3] = 1'b0;
    repeat (3) tick();
    check("evcnt sat", 32'(tmo_cnt[3*EVCNT_W +: EVCNT_W]), 255);
    check("evcnt release tmo", 32'(timeout[3]), 0);
`endif

    // Randomised phase.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(3) == 0) start[i] = ~start[i];
      limit = NCH*N'($urandom);
      tick();
    end
    start = '0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
